// File: rtl/instr_fetch_stage.sv
// Purpose : IF stage - owns the PC, addresses the instruction ROM and registers the returned
//           word into the IF/ID pipeline register; handles stall, flush, redirect, sticky fault.
// Latency : ROM word at PC appears on o_if_id_instr one edge after PC is presented.
// Backpr. : i_stall holds PC and all IF/ID fields; i_flush bubbles IF/ID and refetches the same PC.
//
// Ports:
//   i_clk, i_rst                  clock (rising edge), asynchronous active-high reset
//   i_stall, i_flush              hazard-unit hold / IF/ID invalidate
//   i_redirect_valid/_pc          EX-stage branch/jump target (byte address)
//   o_rom_adr, i_rom_instr        combinational ROM address out / instruction word in
//   o_if_id_valid/_pc/_pc4/_instr IF/ID pipeline register
//   o_fetch_fault                 sticky: PC misaligned or past end of ROM
//   o_fetch_count                 saturating count of valid instructions written to IF/ID
//
// XLEN encoding: 1 = 32-bit, 2 = 64-bit; PC width is 1 << (XLEN+4).
module instr_fetch_stage #(
   parameter  int              XLEN     = 2,
   localparam int              PC_W     = 1 << (XLEN + 4),
   parameter  logic [PC_W-1:0] RESET_PC = '0,
   parameter  logic [PC_W-1:0] TEXT_HI  = PC_W'('h3FF),
   parameter  logic [31:0]     NOP      = 32'h0000_0013
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_stall,
   input  logic            i_flush,
   input  logic            i_redirect_valid,
   input  logic [PC_W-1:0] i_redirect_pc,
   output logic [PC_W-1:0] o_rom_adr,
   input  logic [31:0]     i_rom_instr,
   output logic            o_if_id_valid,
   output logic [PC_W-1:0] o_if_id_pc,
   output logic [PC_W-1:0] o_if_id_pc4,
   output logic [31:0]     o_if_id_instr,
   output logic            o_fetch_fault,
   output logic [31:0]     o_fetch_count
);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   localparam logic [PC_W-1:0] LAST_WORD = TEXT_HI - PC_W'(3);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            valid_q, valid_d;
   logic [PC_W-1:0] if_pc_q, if_pc_d;
   logic [PC_W-1:0] if_pc4_q, if_pc4_d;
   logic [31:0]     instr_q, instr_d;
   logic            fault_q, fault_d;
   logic [31:0]     count_q, count_d;

   logic            pc_illegal;
   logic [PC_W-1:0] pc_plus4;

   // A word fetch must be aligned and lie entirely inside the ROM.
   assign pc_illegal = (pc_q[1:0] != 2'b00) || (pc_q > LAST_WORD);
   assign pc_plus4   = pc_q + PC_W'(4);

   // Steer an illegal PC to address 0 so the ROM index never leaves its array.
   assign o_rom_adr  = pc_illegal ? '0 : pc_q;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      valid_d  = valid_q;
      if_pc_d  = if_pc_q;
      if_pc4_d = if_pc4_q;
      instr_d  = instr_q;
      fault_d  = fault_q;
      count_d  = count_q;

      unique case (state_q)
         ST_BOOT: begin
            // One settling cycle: IF/ID stays invalid, PC untouched.
            state_d = ST_RUN;
         end
         ST_RUN, ST_HALT: begin
            if (i_redirect_valid) begin
               // Redirect wins over everything, including stall, and clears a fault.
               state_d = ST_RUN;
               pc_d    = i_redirect_pc;
               valid_d = 1'b0;
               instr_d = NOP;
               fault_d = 1'b0;
            end else if (state_q == ST_RUN) begin
               if (i_flush) begin
                  valid_d = 1'b0;
                  instr_d = NOP;
               end else if (i_stall) begin
                  // hold everything
               end else if (pc_illegal) begin
                  state_d = ST_HALT;
                  fault_d = 1'b1;
                  valid_d = 1'b0;
                  instr_d = NOP;
               end else begin
                  valid_d  = 1'b1;
                  if_pc_d  = pc_q;
                  if_pc4_d = pc_plus4;
                  instr_d  = i_rom_instr;
                  pc_d     = pc_plus4;
                  count_d  = (count_q == 32'hFFFF_FFFF) ? count_q : count_q + 32'd1;
               end
            end
            // HALT without redirect: PC, fault and bubble simply hold.
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_PC;
         valid_q  <= 1'b0;
         if_pc_q  <= '0;
         if_pc4_q <= '0;
         instr_q  <= NOP;
         fault_q  <= 1'b0;
         count_q  <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         if_pc_q  <= if_pc_d;
         if_pc4_q <= if_pc4_d;
         instr_q  <= instr_d;
         fault_q  <= fault_d;
         count_q  <= count_d;
      end
   end

   assign o_if_id_valid = valid_q;
   assign o_if_id_pc    = if_pc_q;
   assign o_if_id_pc4   = if_pc4_q;
   assign o_if_id_instr = instr_q;
   assign o_fetch_fault = fault_q;
   assign o_fetch_count = count_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

   localparam int          PC_W    = 64;
   localparam logic [63:0] TEXT_HI = 64'hFF;
   localparam logic [31:0] NOP     = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst, stall, flush, rv;
   logic [63:0] rpc, rom_adr, if_pc, if_pc4;
   logic [31:0] rom_instr, if_instr, cnt;
   logic        vld, fault;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_pc;
   logic [31:0] exp_count;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [63:0] a);
      return 32'hA000_0000 | {4'h0, a[27:0]};
   endfunction

   assign rom_instr = rom_word(rom_adr);

   instr_fetch_stage #(
      .XLEN    (2),
      .RESET_PC(64'h0),
      .TEXT_HI (TEXT_HI),
      .NOP     (NOP)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_stall         (stall),
      .i_flush         (flush),
      .i_redirect_valid(rv),
      .i_redirect_pc   (rpc),
      .o_rom_adr       (rom_adr),
      .i_rom_instr     (rom_instr),
      .o_if_id_valid   (vld),
      .o_if_id_pc      (if_pc),
      .o_if_id_pc4     (if_pc4),
      .o_if_id_instr   (if_instr),
      .o_fetch_fault   (fault),
      .o_fetch_count   (cnt)
   );

   // Advance one edge; outputs are then sampled 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0; rv = 1'b0; rpc = '0;
      #2;
      checks++;
      if (vld !== 1'b0 || if_pc !== 64'h0 || if_pc4 !== 64'h0 || if_instr !== NOP ||
          fault !== 1'b0 || cnt !== 32'h0 || rom_adr !== 64'h0) begin
         errors++;
         $display("FAIL reset_state: v=%b pc=%h pc4=%h instr=%h fault=%b cnt=%0d adr=%h, want 0/0/0/%h/0/0/0",
                  vld, if_pc, if_pc4, if_instr, fault, cnt, rom_adr, NOP);
      end
      tick();
      rst = 1'b0;
      exp_pc = 64'h0;
      exp_count = 32'h0;
      tick(); // BOOT edge
      checks++;
      if (vld !== 1'b0 || rom_adr !== 64'h0 || cnt !== 32'h0) begin
         errors++;
         $display("FAIL boot_cycle: v=%b adr=%h cnt=%0d, want v=0 adr=0 cnt=0", vld, rom_adr, cnt);
      end
   endtask

   task automatic test_fetch(input int n, input string tag);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         checks++;
         if (rom_adr !== exp_pc) begin
            errors++;
            $display("FAIL %s_rom_adr: got %h, want %h", tag, rom_adr, exp_pc);
         end
         sb.push_back('{pc: exp_pc, instr: rom_word(exp_pc)});
         if (exp_count != 32'hFFFF_FFFF) exp_count++;
         tick();
         e = sb.pop_front();
         checks++;
         if (vld !== 1'b1 || if_pc !== e.pc || if_pc4 !== e.pc + 64'd4 || if_instr !== e.instr) begin
            errors++;
            $display("FAIL %s_ifid: got v=%b pc=%h pc4=%h instr=%h, want v=1 pc=%h pc4=%h instr=%h",
                     tag, vld, if_pc, if_pc4, if_instr, e.pc, e.pc + 64'd4, e.instr);
         end
         exp_pc = exp_pc + 64'd4;
      end
      checks++;
      if (cnt !== exp_count) begin
         errors++;
         $display("FAIL %s_count: got %0d, want %0d", tag, cnt, exp_count);
      end
   endtask

   task automatic test_stall();
      stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if (vld !== 1'b1 || if_pc !== exp_pc - 64'd4 || if_instr !== rom_word(exp_pc - 64'd4) ||
             rom_adr !== exp_pc || cnt !== exp_count) begin
            errors++;
            $display("FAIL stall_hold%0d: v=%b pc=%h instr=%h adr=%h cnt=%0d, want v=1 pc=%h instr=%h adr=%h cnt=%0d",
                     i, vld, if_pc, if_instr, rom_adr, cnt, exp_pc - 64'd4, rom_word(exp_pc - 64'd4),
                     exp_pc, exp_count);
         end
      end
      stall = 1'b0;
      test_fetch(1, "stall_resume");
   endtask

   task automatic test_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++;
      if (vld !== 1'b0 || if_instr !== NOP || rom_adr !== exp_pc || if_pc !== exp_pc - 64'd4) begin
         errors++;
         $display("FAIL flush_bubble: v=%b instr=%h adr=%h pc=%h, want v=0 instr=%h adr=%h pc=%h",
                  vld, if_instr, rom_adr, if_pc, NOP, exp_pc, exp_pc - 64'd4);
      end
      test_fetch(1, "flush_refetch");
   endtask

   task automatic test_redirect();
      stall = 1'b1; rv = 1'b1; rpc = 64'h40;
      tick();
      stall = 1'b0; rv = 1'b0;
      checks++;
      if (vld !== 1'b0 || if_instr !== NOP || rom_adr !== 64'h40) begin
         errors++;
         $display("FAIL redirect_bubble: v=%b instr=%h adr=%h, want v=0 instr=%h adr=40", vld, if_instr, rom_adr, NOP);
      end
      exp_pc = 64'h40;
      test_fetch(1, "redirect_target");
   endtask

   task automatic test_fault_misaligned();
      rv = 1'b1; rpc = 64'h42;
      tick();
      rv = 1'b0;
      checks++;
      if (fault !== 1'b0 || rom_adr !== 64'h0 || vld !== 1'b0) begin
         errors++;
         $display("FAIL misalign_accept: fault=%b adr=%h v=%b, want 0/0/0", fault, rom_adr, vld);
      end
      tick();
      checks++;
      if (fault !== 1'b1 || rom_adr !== 64'h0 || vld !== 1'b0) begin
         errors++;
         $display("FAIL misalign_fault: fault=%b adr=%h v=%b, want 1/0/0", fault, rom_adr, vld);
      end
      stall = 1'b1; flush = 1'b1;
      tick();
      stall = 1'b0; flush = 1'b0;
      tick();
      checks++;
      if (fault !== 1'b1 || vld !== 1'b0 || cnt !== exp_count || rom_adr !== 64'h0) begin
         errors++;
         $display("FAIL halt_sticky: fault=%b v=%b cnt=%0d adr=%h, want 1/0/%0d/0", fault, vld, cnt, rom_adr, exp_count);
      end
      rv = 1'b1; rpc = 64'h0;
      tick();
      rv = 1'b0;
      checks++;
      if (fault !== 1'b0 || vld !== 1'b0) begin
         errors++;
         $display("FAIL fault_clear: fault=%b v=%b, want 0/0", fault, vld);
      end
      exp_pc = 64'h0;
      test_fetch(1, "after_clear");
   endtask

   task automatic test_boundary();
      rv = 1'b1; rpc = TEXT_HI - 64'd7;
      tick();
      rv = 1'b0;
      exp_pc = TEXT_HI - 64'd7;
      test_fetch(2, "boundary");
      checks++;
      if (rom_adr !== 64'h0 || fault !== 1'b0) begin
         errors++;
         $display("FAIL boundary_oob_adr: adr=%h fault=%b, want 0/0", rom_adr, fault);
      end
      tick();
      checks++;
      if (fault !== 1'b1 || vld !== 1'b0 || if_pc !== TEXT_HI - 64'd3 || cnt !== exp_count) begin
         errors++;
         $display("FAIL boundary_fault: fault=%b v=%b pc=%h cnt=%0d, want 1/0/%h/%0d",
                  fault, vld, if_pc, cnt, TEXT_HI - 64'd3, exp_count);
      end
   endtask

   task automatic test_reset_midrun();
      rv = 1'b1; rpc = 64'h0;
      tick();
      rv = 1'b0;
      exp_pc = 64'h0;
      test_fetch(2, "pre_reset");
      #3 rst = 1'b1;
      #1;
      checks++;
      if (vld !== 1'b0 || if_pc !== 64'h0 || if_pc4 !== 64'h0 || if_instr !== NOP ||
          fault !== 1'b0 || cnt !== 32'h0 || rom_adr !== 64'h0) begin
         errors++;
         $display("FAIL midrun_reset: v=%b pc=%h pc4=%h instr=%h fault=%b cnt=%0d adr=%h, want all reset values",
                  vld, if_pc, if_pc4, if_instr, fault, cnt, rom_adr);
      end
      tick();
      rst = 1'b0;
      exp_pc = 64'h0;
      exp_count = 32'h0;
      tick();
      test_fetch(1, "post_reset");
   endtask

   initial begin
      test_reset();
      test_fetch(2, "normal");
      test_stall();
      test_flush();
      test_redirect();
      test_fault_misaligned();
      test_boundary();
      test_reset_midrun();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
